// File: rtl/timer_pkg.sv
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared types and constants for the programmable timer block
//            (state encoding, register offsets, divider tap indices).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  // Overflow sequencing states
  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_OVF    = 2'd1,
    T_RELOAD = 2'd2
  } timer_state_t;

  // Register offsets inside FF04-FF07
  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  // Divider tap indices selected by TAC[1:0]
  localparam logic [1:0] TAP_4096   = 2'd0;
  localparam logic [1:0] TAP_262144 = 2'd1;
  localparam logic [1:0] TAP_65536  = 2'd2;
  localparam logic [1:0] TAP_16384  = 2'd3;

  // Read value of the TAC register with the unused upper bits padded
  function automatic logic [7:0] tac_readback(input logic [4:0] pad,
                                              input logic [2:0] tac);
    return {pad, tac};
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_tick.sv
// ============================================================================
// Module   : timer_tick
// Purpose  : Divider tap multiplexer and falling-edge detector. Produces a
//            one-cycle increment request when the gated tap falls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_tick
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       enable,
  input  logic [1:0] tap_sel,
  input  logic [3:0] div_tap,
  output logic       inc
);

  logic t;
  logic t_q;

  // Gated tick: enable bit ANDed with the selected divider tap. Because the
  // enable gates the tap directly, clearing it can itself produce a fall.
  always_comb begin
    t = enable & div_tap[tap_sel];
  end

  // Tap history, sampled every machine cycle
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      t_q <= 1'b0;
    end else begin
      t_q <= t;
    end
  end

  assign inc = t_q & ~t;

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// Module   : timer_ctrl
// Purpose  : TIMA/TMA/TAC timer sequencer with overflow reload and interrupt,
//            plus FF04 (DIV) decode and FF04-FF07 readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_ctrl
  import timer_pkg::*;
#(
  parameter logic [2:0] TAC_RST = 3'b000,
  parameter logic [4:0] TAC_PAD = 5'h1f
)
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       sel,
  input  logic [1:0] addr,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] div_hi,
  input  logic [3:0] div_tap,
  output logic       div_clr,
  output logic       irq_timer
);

  timer_state_t state, state_n;
  logic [7:0]   tima, tima_n;
  logic [7:0]   tma, tma_n;
  logic [2:0]   tac;
  logic         inc;
  logic [8:0]   tima_sum;
  logic         wr_div, wr_tima, wr_tma, wr_tac;

  timer_tick u_tick (
    .clk     (clk),
    .nreset  (nreset),
    .enable  (tac[2]),
    .tap_sel (tac[1:0]),
    .div_tap (div_tap),
    .inc     (inc)
  );

  assign wr_div  = sel & cpu_wr & (addr == REG_DIV);
  assign wr_tima = sel & cpu_wr & (addr == REG_TIMA);
  assign wr_tma  = sel & cpu_wr & (addr == REG_TMA);
  assign wr_tac  = sel & cpu_wr & (addr == REG_TAC);

  assign tima_sum = {1'b0, tima} + 9'd1;

  // Next-state and next-TIMA selection for the overflow sequence
  always_comb begin
    state_n = state;
    tima_n  = tima;
    tma_n   = wr_tma ? din : tma;
    case (state)
      T_IDLE: begin
        // A CPU write takes priority over a same-cycle increment
        if (wr_tima) begin
          tima_n = din;
        end else if (inc) begin
          tima_n = tima_sum[7:0];
          if (tima_sum[8]) begin
            state_n = T_OVF;
          end
        end
      end
      T_OVF: begin
        // TIMA sits at zero this cycle; a TIMA write here cancels the reload
        if (wr_tima) begin
          tima_n  = din;
          state_n = T_IDLE;
        end else begin
          tima_n  = tma_n;
          state_n = T_RELOAD;
        end
      end
      T_RELOAD: begin
        // TIMA writes are dropped; a TMA write lands in TIMA as well
        state_n = T_IDLE;
        if (wr_tma) begin
          tima_n = din;
        end else if (inc) begin
          tima_n = tima_sum[7:0];
          if (tima_sum[8]) begin
            state_n = T_OVF;
          end
        end
      end
      default: begin
        state_n = T_IDLE;
      end
    endcase
  end

  // Timer registers and sequencer state
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= T_IDLE;
      tima  <= 8'h00;
      tma   <= 8'h00;
      tac   <= TAC_RST;
    end else begin
      state <= state_n;
      tima  <= tima_n;
      tma   <= tma_n;
      if (wr_tac) begin
        tac <= din[2:0];
      end
    end
  end

  // One-cycle divider clear following a DIV write
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_clr <= 1'b0;
    end else begin
      div_clr <= wr_div;
    end
  end

  // The interrupt is requested for exactly the reload cycle
  assign irq_timer = (state == T_RELOAD);

  // Combinational readback, zero when not addressed
  always_comb begin
    dout = 8'h00;
    if (sel & cpu_rd) begin
      case (addr)
        REG_DIV:  dout = div_hi;
        REG_TIMA: dout = tima;
        REG_TMA:  dout = tma;
        default:  dout = tac_readback(TAC_PAD, tac);
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// Module   : tb_timer_ctrl
// Purpose  : Directed self-checking bench for timer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_ctrl;

  logic       clk;
  logic       nreset;
  logic       sel;
  logic [1:0] addr;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] div_hi;
  logic [3:0] div_tap;
  logic       div_clr;
  logic       irq_timer;

  int checks;
  int errors;
  logic irq_seen;

  timer_ctrl #(.TAC_RST(3'b000), .TAC_PAD(5'h1f)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .sel       (sel),
    .addr      (addr),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .din       (din),
    .dout      (dout),
    .div_hi    (div_hi),
    .div_tap   (div_tap),
    .div_clr   (div_clr),
    .irq_timer (irq_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge irq_timer) irq_seen = 1'b1;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    sel = 1'b1; cpu_rd = 1'b1; addr = a;
    #1;
    v = dout;
    sel = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; cpu_wr = 1'b1; addr = a; din = d;
    cycle();
    sel = 1'b0; cpu_wr = 1'b0;
  endtask

  // One falling edge on tap[1]; TIMA has incremented on return
  task automatic tap_fall();
    div_tap[1] = 1'b1;
    cycle();
    div_tap[1] = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rd(2'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tima got %h exp 00", v); end
    rd(2'd2, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tma got %h exp 00", v); end
    rd(2'd3, v); checks++;
    if (v !== 8'hf8) begin errors++; $display("FAIL reset_tac got %h exp f8", v); end
    checks++;
    if (irq_timer !== 1'b0 || div_clr !== 1'b0) begin
      errors++; $display("FAIL reset_outs got irq=%b clr=%b exp 0 0", irq_timer, div_clr);
    end
  endtask

  task automatic test_reads();
    logic [7:0] v;
    div_hi = 8'ha5;
    rd(2'd0, v); checks++;
    if (v !== 8'ha5) begin errors++; $display("FAIL read_div got %h exp a5", v); end
    sel = 1'b0; cpu_rd = 1'b1; addr = 2'd0;
    #1; checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL read_nosel got %h exp 00", dout); end
    cpu_rd = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    wr(2'd2, 8'h40);
    wr(2'd1, 8'hfe);
    wr(2'd3, 8'h05);
    tap_fall();
    rd(2'd1, v); checks++;
    if (v !== 8'hff) begin errors++; $display("FAIL ovf_ff got %h exp ff", v); end
    tap_fall();
    rd(2'd1, v); checks++;
    if (v !== 8'h00 || irq_timer !== 1'b0) begin
      errors++; $display("FAIL ovf_zero got %h irq=%b exp 00 irq=0", v, irq_timer);
    end
    cycle();
    rd(2'd1, v); checks++;
    if (v !== 8'h40 || irq_timer !== 1'b1) begin
      errors++; $display("FAIL ovf_reload got %h irq=%b exp 40 irq=1", v, irq_timer);
    end
    cycle();
    checks++;
    if (irq_timer !== 1'b0) begin errors++; $display("FAIL ovf_irq_pulse got %b exp 0", irq_timer); end
    tap_fall();
    rd(2'd1, v); checks++;
    if (v !== 8'h41) begin errors++; $display("FAIL ovf_next got %h exp 41", v); end
  endtask

  task automatic test_ovf_write();
    logic [7:0] v;
    irq_seen = 1'b0;
    wr(2'd1, 8'hff);
    tap_fall();
    wr(2'd1, 8'h12);
    cycle(); cycle();
    rd(2'd1, v); checks++;
    if (v !== 8'h12 || irq_seen !== 1'b0) begin
      errors++; $display("FAIL ovf_cancel got %h irq_seen=%b exp 12 0", v, irq_seen);
    end
  endtask

  task automatic test_reload_write();
    logic [7:0] v;
    wr(2'd1, 8'hff);
    tap_fall();
    cycle();
    checks++;
    if (irq_timer !== 1'b1) begin errors++; $display("FAIL reload_irq got %b exp 1", irq_timer); end
    wr(2'd1, 8'h12);
    rd(2'd1, v); checks++;
    if (v !== 8'h40) begin errors++; $display("FAIL reload_tima_wr got %h exp 40", v); end
    wr(2'd1, 8'hff);
    tap_fall();
    cycle();
    wr(2'd2, 8'h77);
    rd(2'd1, v); checks++;
    if (v !== 8'h77) begin errors++; $display("FAIL reload_tma_wr tima got %h exp 77", v); end
    rd(2'd2, v); checks++;
    if (v !== 8'h77) begin errors++; $display("FAIL reload_tma_wr tma got %h exp 77", v); end
  endtask

  task automatic test_quirks();
    logic [7:0] v;
    wr(2'd3, 8'h04);
    wr(2'd1, 8'h20);
    div_tap[0] = 1'b1;
    cycle();
    wr(2'd0, 8'h00);
    checks++;
    if (div_clr !== 1'b1) begin errors++; $display("FAIL div_clr_pulse got %b exp 1", div_clr); end
    div_tap[0] = 1'b0;
    cycle();
    checks++;
    if (div_clr !== 1'b0) begin errors++; $display("FAIL div_clr_end got %b exp 0", div_clr); end
    rd(2'd1, v); checks++;
    if (v !== 8'h21) begin errors++; $display("FAIL div_quirk got %h exp 21", v); end
    div_tap[0] = 1'b1;
    cycle();
    wr(2'd3, 8'h00);
    cycle();
    rd(2'd1, v); checks++;
    if (v !== 8'h22) begin errors++; $display("FAIL tac_quirk got %h exp 22", v); end
    div_tap[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    wr(2'd3, 8'h05);
    wr(2'd1, 8'h10);
    div_tap[1] = 1'b1;
    cycle();
    div_tap[1] = 1'b0;
    wr(2'd1, 8'h30);
    rd(2'd1, v); checks++;
    if (v !== 8'h30) begin errors++; $display("FAIL wr_beats_inc got %h exp 30", v); end
  endtask

  task automatic test_reset_in_ovf();
    logic [7:0] v;
    wr(2'd2, 8'h55);
    wr(2'd1, 8'hff);
    tap_fall();
    irq_seen = 1'b0;
    nreset = 1'b0;
    #2;
    rd(2'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_ovf_tima got %h exp 00", v); end
    rd(2'd2, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_ovf_tma got %h exp 00", v); end
    rd(2'd3, v); checks++;
    if (v !== 8'hf8) begin errors++; $display("FAIL rst_ovf_tac got %h exp f8", v); end
    cycle(); cycle();
    nreset = 1'b1;
    cycle(); cycle(); cycle();
    checks++;
    if (irq_seen !== 1'b0) begin errors++; $display("FAIL rst_ovf_irq got %b exp 0", irq_seen); end
    wr(2'd3, 8'h05);
    wr(2'd1, 8'hfe);
    tap_fall();
    rd(2'd1, v); checks++;
    if (v !== 8'hff) begin errors++; $display("FAIL rst_resume got %h exp ff", v); end
  endtask

  initial begin
    checks = 0; errors = 0; irq_seen = 1'b0;
    nreset = 1'b0; sel = 1'b0; addr = 2'd0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    din = 8'h00; div_hi = 8'h00; div_tap = 4'h0;
    cycle(); cycle();
    test_reset();
    nreset = 1'b1;
    cycle();
    test_reads();
    test_overflow();
    test_ovf_write();
    test_reload_write();
    test_quirks();
    test_back_to_back();
    test_reset_in_ovf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
